k051960_render_feed: RTL and testbench



---
 rtl/k051960_render_feed_pkg.sv | 17 +
 rtl/k051960_render_feed_spr_group_counter.sv | 44 ++++
 rtl/k051960_render_feed.sv | 130 +++++++++++++
 tb/tb_k051960_render_feed.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/k051960_render_feed_pkg.sv
// Shared types and field widths for the k051960 sprite render-command feed.
package k051960_render_feed_pkg;
  localparam int CODE_W          = 14;
  localparam int ROW_W           = 4;
  localparam int X_W             = 9;
  localparam int COLOR_W         = 8;
  localparam int LINE_BUDGET_DEF = 768;
  localparam int GRP_W_DEF       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LATCH,
    ST_DRAW,
    ST_END
  } state_e;
endpackage

// File: rtl/k051960_render_feed_spr_group_counter.sv
// Per-sprite group index and 4-cycle phase; exposes next-cycle values so the
// owner can register rom_req/rom_addr aligned with the DRAW cycle they belong to.
module k051960_render_feed_spr_group_counter #(
  parameter int GRP_W = 3
) (
  input  logic             clk_12M,
  input  logic             RES,
  input  logic             load,
  input  logic             adv,
  input  logic             hflip,
  input  logic [GRP_W-1:0] grps,
  output logic [GRP_W-1:0] grp_field_nxt,
  output logic             first_nxt,
  output logic             done
);
  logic [GRP_W-1:0] g_q, g_n;
  logic [1:0]       ph_q, ph_n;

  always_comb begin
    g_n  = g_q;
    ph_n = ph_q;
    if (load) begin
      g_n  = '0;
      ph_n = '0;
    end else if (adv) begin
      ph_n = ph_q + 2'd1;
      if (ph_q == 2'd3) g_n = g_q + GRP_W'(1);
    end
  end

  assign done          = (g_q == grps) && (ph_q == 2'd3);
  assign first_nxt     = (ph_n == 2'd0);
  assign grp_field_nxt = hflip ? (grps - g_n) : g_n;

  always_ff @(posedge clk_12M) begin
    if (RES) begin
      g_q  <= '0;
      ph_q <= '0;
    end else begin
      g_q  <= g_n;
      ph_q <= ph_n;
    end
  end
endmodule

// File: rtl/k051960_render_feed.sv
// Sprite render-command sequencer feeding the k051937 line-buffer writer:
// LACH/HP/OC/OHF per sprite, CARY while drawing, one ROM fetch per 8-pixel group.
module k051960_render_feed
  import k051960_render_feed_pkg::*;
#(
  parameter int LINE_BUDGET = LINE_BUDGET_DEF,
  parameter int GRP_W       = GRP_W_DEF
) (
  input  logic                            clk_12M,
  input  logic                            RES,
  input  logic                            line_start,
  input  logic                            spr_valid,
  output logic                            spr_ready,
  input  logic [X_W-1:0]                  spr_x,
  input  logic [COLOR_W-1:0]              spr_color,
  input  logic                            spr_hflip,
  input  logic [CODE_W-1:0]               spr_code,
  input  logic [ROW_W-1:0]                spr_row,
  input  logic [GRP_W-1:0]                spr_grps,
  input  logic                            spr_last,
  output logic [X_W-1:0]                  HP,
  output logic [COLOR_W-1:0]              OC,
  output logic                            OHF,
  output logic                            LACH,
  output logic                            CARY,
  output logic                            HEND,
  output logic                            rom_req,
  output logic [CODE_W+ROW_W+GRP_W-1:0]   rom_addr,
  output logic                            ovf
);
  localparam int BW = $clog2(LINE_BUDGET + 1);

  state_e            state_q, state_n;
  logic [BW-1:0]     bud_q;
  logic              abort_q;
  logic [CODE_W-1:0] code_q;
  logic [ROW_W-1:0]  row_q;
  logic [GRP_W-1:0]  grps_q;
  logic              last_q;
  logic              active, exhaust, done, first_nxt;
  logic [GRP_W-1:0]  grp_nxt;
  logic              lach_d, cary_d, hend_d, req_d;

  assign active  = state_q inside {ST_WAIT, ST_LATCH, ST_DRAW};
  // Budget hits zero on this edge; that edge moves straight to END.
  assign exhaust = active && (bud_q == BW'(1));

  k051960_render_feed_spr_group_counter #(.GRP_W(GRP_W)) u_grp (
    .clk_12M       (clk_12M),
    .RES           (RES),
    .load          (state_q == ST_LATCH),
    .adv           (state_q == ST_DRAW),
    .hflip         (OHF),
    .grps          (grps_q),
    .grp_field_nxt (grp_nxt),
    .first_nxt     (first_nxt),
    .done          (done)
  );

  always_ff @(posedge clk_12M) begin
    if (RES) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (line_start) state_n = ST_WAIT;
      ST_END:  state_n = (line_start || abort_q) ? ST_WAIT : ST_IDLE;
      default: begin
        if (line_start || exhaust)  state_n = ST_END;
        else if (state_q == ST_WAIT) begin
          if (spr_valid) state_n = ST_LATCH;
        end
        else if (state_q == ST_LATCH) state_n = ST_DRAW;
        else if (done) state_n = last_q ? ST_END : (spr_valid ? ST_LATCH : ST_WAIT);
      end
    endcase
  end

  // Outputs decode the next state so every port comes straight from a flop.
  always_comb begin
    lach_d = (state_n == ST_LATCH);
    cary_d = (state_n == ST_DRAW);
    hend_d = (state_n == ST_END);
    req_d  = cary_d && first_nxt;
  end

  always_ff @(posedge clk_12M) begin
    if (RES) begin
      spr_ready <= 1'b0;
      HP        <= '0;
      OC        <= '0;
      OHF       <= 1'b0;
      LACH      <= 1'b0;
      CARY      <= 1'b0;
      HEND      <= 1'b0;
      rom_req   <= 1'b0;
      rom_addr  <= '0;
      ovf       <= 1'b0;
      code_q    <= '0;
      row_q     <= '0;
      grps_q    <= '0;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      bud_q     <= '0;
    end else begin
      spr_ready <= lach_d;
      LACH      <= lach_d;
      CARY      <= cary_d;
      HEND      <= hend_d;
      rom_req   <= req_d;
      abort_q   <= active && line_start;
      if (lach_d) begin
        HP     <= spr_x;
        OC     <= spr_color;
        OHF    <= spr_hflip;
        code_q <= spr_code;
        row_q  <= spr_row;
        grps_q <= spr_grps;
        last_q <= spr_last;
      end
      if (req_d) rom_addr <= {code_q, row_q, grp_nxt};
      if (state_n == ST_WAIT && !active)            bud_q <= BW'(LINE_BUDGET);
      else if (state_q != ST_IDLE && bud_q != '0)   bud_q <= bud_q - BW'(1);
      if (line_start)   ovf <= 1'b0;
      else if (exhaust) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_k051960_render_feed.sv
// Directed bench for k051960_render_feed (LINE_BUDGET=20 instance).
module tb_k051960_render_feed;
  logic        clk_12M = 1'b0;
  logic        RES, line_start, spr_valid, spr_hflip, spr_last;
  logic [8:0]  spr_x;
  logic [7:0]  spr_color;
  logic [13:0] spr_code;
  logic [3:0]  spr_row;
  logic [2:0]  spr_grps;
  logic        spr_ready, OHF, LACH, CARY, HEND, rom_req, ovf;
  logic [8:0]  HP;
  logic [7:0]  OC;
  logic [20:0] rom_addr;
  logic [4:0]  ctl;
  int checks = 0;
  int passes = 0;

  assign ctl = {spr_ready, LACH, CARY, HEND, rom_req};

  k051960_render_feed #(.LINE_BUDGET(20), .GRP_W(3)) dut (
    .clk_12M(clk_12M), .RES(RES), .line_start(line_start), .spr_valid(spr_valid),
    .spr_ready(spr_ready), .spr_x(spr_x), .spr_color(spr_color), .spr_hflip(spr_hflip),
    .spr_code(spr_code), .spr_row(spr_row), .spr_grps(spr_grps), .spr_last(spr_last),
    .HP(HP), .OC(OC), .OHF(OHF), .LACH(LACH), .CARY(CARY), .HEND(HEND),
    .rom_req(rom_req), .rom_addr(rom_addr), .ovf(ovf)
  );

  always #5 clk_12M = ~clk_12M;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_12M); #1;
  endtask

  task automatic do_reset();
    RES = 1'b1; line_start = 1'b0; spr_valid = 1'b0;
    step(); step();
    RES = 1'b0;
  endtask

  task automatic set_entry(input logic [8:0] x, input logic [7:0] c, input logic h,
                           input logic [13:0] code, input logic [3:0] row,
                           input logic [2:0] g, input logic l);
    spr_x = x; spr_color = c; spr_hflip = h; spr_code = code;
    spr_row = row; spr_grps = g; spr_last = l;
  endtask

  task automatic test_reset();
    set_entry(9'h0, 8'h0, 1'b0, 14'h0, 4'h0, 3'd0, 1'b0);
    do_reset();
    checks++; if ({HP, OC, OHF, ctl, rom_addr, ovf} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {HP, OC, OHF, ctl, rom_addr, ovf}); else passes++;
    spr_valid = 1'b1;
    step(); step(); step();
    checks++; if (ctl !== 5'b00000)
      $display("FAIL reset_idle_hold got=%b exp=00000", ctl); else passes++;
  endtask

  task automatic test_single();
    do_reset();
    set_entry(9'h040, 8'h5A, 1'b0, 14'h1234, 4'h5, 3'd1, 1'b1);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    checks++; if (ctl !== 5'b00000) $display("FAIL single_wait got=%b exp=00000", ctl); else passes++;
    step(); spr_valid = 1'b0;
    checks++; if ({ctl, HP, OC, OHF} !== {5'b11000, 9'h040, 8'h5A, 1'b0})
      $display("FAIL single_latch got=%b/%h/%h/%b exp=11000/040/5a/0", ctl, HP, OC, OHF); else passes++;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (ctl !== {4'b0010, i % 4 == 0})
        $display("FAIL single_draw%0d got=%b exp=%b", i, ctl, {4'b0010, i % 4 == 0}); else passes++;
      if (i % 4 == 0) begin
        checks++; if (rom_addr !== {14'h1234, 4'h5, 3'(i / 4)})
          $display("FAIL single_addr%0d got=%h exp=%h", i, rom_addr, {14'h1234, 4'h5, 3'(i / 4)}); else passes++;
      end
    end
    step();
    checks++; if (ctl !== 5'b00010) $display("FAIL single_hend got=%b exp=00010", ctl); else passes++;
    step();
    checks++; if ({ctl, HP} !== {5'b00000, 9'h040})
      $display("FAIL single_after got=%b/%h exp=00000/040", ctl, HP); else passes++;
  endtask

  task automatic test_hflip();
    do_reset();
    set_entry(9'h1FF, 8'hC3, 1'b1, 14'h3ABC, 4'hA, 3'd3, 1'b1);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    step(); spr_valid = 1'b0;
    checks++; if ({ctl, HP, OC, OHF} !== {5'b11000, 9'h1FF, 8'hC3, 1'b1})
      $display("FAIL hflip_latch got=%b/%h/%h/%b exp=11000/1ff/c3/1", ctl, HP, OC, OHF); else passes++;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if ({ctl, OHF} !== {4'b0010, i % 4 == 0, 1'b1})
        $display("FAIL hflip_draw%0d got=%b exp=%b", i, {ctl, OHF}, {4'b0010, i % 4 == 0, 1'b1}); else passes++;
      if (i % 4 == 0) begin
        checks++; if (rom_addr !== {14'h3ABC, 4'hA, 3'(3 - i / 4)})
          $display("FAIL hflip_addr%0d got=%h exp=%h", i, rom_addr, {14'h3ABC, 4'hA, 3'(3 - i / 4)}); else passes++;
      end
    end
    step();
    checks++; if (ctl !== 5'b00010) $display("FAIL hflip_hend got=%b exp=00010", ctl); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [8:0]  xs [3];
    logic [13:0] cs [3];
    xs = '{9'h010, 9'h020, 9'h030};
    cs = '{14'h0001, 14'h0002, 14'h0003};
    do_reset();
    set_entry(xs[0], 8'h11, 1'b0, cs[0], 4'h0, 3'd0, 1'b0);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      checks++; if ({ctl, HP} !== {5'b11000, xs[e]})
        $display("FAIL b2b_latch%0d got=%b/%h exp=11000/%h", e, ctl, HP, xs[e]); else passes++;
      if (e < 2) set_entry(xs[e+1], 8'h22, 1'b0, cs[e+1], 4'h0, 3'd0, e == 1);
      for (int i = 0; i < 4; i++) begin
        step();
        checks++; if (ctl !== {4'b0010, i == 0})
          $display("FAIL b2b_draw%0d_%0d got=%b exp=%b", e, i, ctl, {4'b0010, i == 0}); else passes++;
        if (i == 0) begin
          checks++; if (rom_addr !== {cs[e], 4'h0, 3'd0})
            $display("FAIL b2b_addr%0d got=%h exp=%h", e, rom_addr, {cs[e], 4'h0, 3'd0}); else passes++;
        end
      end
    end
    step();
    checks++; if (ctl !== 5'b00010) $display("FAIL b2b_hend got=%b exp=00010", ctl); else passes++;
    step();
    checks++; if (ctl !== 5'b00000) $display("FAIL b2b_idle got=%b exp=00000", ctl); else passes++;
    spr_valid = 1'b0;
  endtask

  task automatic test_budget();
    do_reset();
    set_entry(9'h100, 8'h33, 1'b0, 14'h0ABC, 4'h3, 3'd7, 1'b1);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    step(); spr_valid = 1'b0;
    // 20-cycle budget: WAIT + LATCH + 18 DRAW cycles, then forced END.
    for (int i = 0; i < 18; i++) begin
      step();
      checks++; if ({ctl, ovf} !== {4'b0010, i % 4 == 0, 1'b0})
        $display("FAIL budget_draw%0d got=%b exp=%b", i, {ctl, ovf}, {4'b0010, i % 4 == 0, 1'b0}); else passes++;
    end
    checks++; if (rom_addr !== {14'h0ABC, 4'h3, 3'd4})
      $display("FAIL budget_lastaddr got=%h exp=%h", rom_addr, {14'h0ABC, 4'h3, 3'd4}); else passes++;
    step();
    checks++; if ({ctl, ovf} !== 6'b000101)
      $display("FAIL budget_end got=%b exp=000101", {ctl, ovf}); else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({ctl, ovf} !== 6'b000001)
        $display("FAIL budget_sticky%0d got=%b exp=000001", i, {ctl, ovf}); else passes++;
    end
    line_start = 1'b1;
    step(); line_start = 1'b0;
    checks++; if ({ctl, ovf} !== 6'b000000)
      $display("FAIL budget_clear got=%b exp=000000", {ctl, ovf}); else passes++;
  endtask

  task automatic test_abort();
    do_reset();
    set_entry(9'h0A0, 8'h44, 1'b0, 14'h0100, 4'h1, 3'd3, 1'b0);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    step(); spr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (CARY !== 1'b1) $display("FAIL abort_draw%0d got=%b exp=1", i, CARY); else passes++;
    end
    set_entry(9'h077, 8'h77, 1'b0, 14'h0777, 4'h7, 3'd0, 1'b1);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    checks++; if ({ctl, HP} !== {5'b00010, 9'h0A0})
      $display("FAIL abort_end got=%b/%h exp=00010/0a0", ctl, HP); else passes++;
    step();
    checks++; if ({ctl, ovf} !== 6'b000000)
      $display("FAIL abort_wait got=%b exp=000000", {ctl, ovf}); else passes++;
    step(); spr_valid = 1'b0;
    checks++; if ({ctl, HP, OC} !== {5'b11000, 9'h077, 8'h77})
      $display("FAIL abort_relatch got=%b/%h/%h exp=11000/077/77", ctl, HP, OC); else passes++;
    step(); step(); step(); step(); step();
    checks++; if ({ctl, ovf} !== 6'b000100)
      $display("FAIL abort_newend got=%b exp=000100", {ctl, ovf}); else passes++;
  endtask

  task automatic test_res_mid();
    do_reset();
    set_entry(9'h155, 8'h99, 1'b1, 14'h2222, 4'h2, 3'd3, 1'b1);
    spr_valid = 1'b1; line_start = 1'b1;
    step(); line_start = 1'b0;
    step(); step(); step();
    checks++; if (CARY !== 1'b1) $display("FAIL res_predraw got=%b exp=1", CARY); else passes++;
    RES = 1'b1;
    step(); RES = 1'b0;
    checks++; if ({HP, OC, OHF, ctl, rom_addr, ovf} !== '0)
      $display("FAIL res_zero got=%h exp=0", {HP, OC, OHF, ctl, rom_addr, ovf}); else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ctl !== 5'b00000) $display("FAIL res_idle%0d got=%b exp=00000", i, ctl); else passes++;
    end
    line_start = 1'b1;
    step(); line_start = 1'b0;
    step();
    checks++; if ({ctl, HP} !== {5'b11000, 9'h155})
      $display("FAIL res_restart got=%b/%h exp=11000/155", ctl, HP); else passes++;
    spr_valid = 1'b0;
  endtask

  initial begin
    RES = 1'b1; line_start = 1'b0; spr_valid = 1'b0;
    test_reset();
    test_single();
    test_hflip();
    test_back_to_back();
    test_budget();
    test_abort();
    test_res_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
